// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle logic/arith ops, iterative shift-add multiply
// and restoring divide. Define ALU_MC_REM_EN to return the division remainder on Long.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] Long,
   output logic [3:0]       ALUFlags
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
   localparam logic [3:0] OP_MUL  = 4'b0100;
   localparam logic [3:0] OP_SMUL = 4'b0101;
   localparam logic [3:0] OP_UMUL = 4'b0110;
   localparam logic [3:0] OP_DIV  = 4'b0111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] md_q, md_d;
   logic             neg_q, neg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] long_q, long_d;
   logic [3:0]       flags_q, flags_d;

   logic [WIDTH-1:0] b_eff, sc_result;
   logic [WIDTH:0]   sum;
   logic [3:0]       sc_flags;

   always_comb begin
      b_eff     = ALUControl[0] ? ~b : b;
      sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ALUControl[0]};
      sc_result = '0;
      sc_flags  = '0;
      case (ALUControl)
         4'b0000, 4'b0001: begin
            sc_result   = sum[WIDTH-1:0];
            sc_flags[1] = sum[WIDTH];
            sc_flags[0] = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0010: sc_result = a & b;
         4'b0011: sc_result = a | b;
         4'b1000: sc_result = a ^ b;
         4'b1001: sc_result = b;
         // any set bit above the shift field means a shift of WIDTH or more
         4'b1010: sc_result = ((b >> SHW) == '0) ? (a << b[SHW-1:0]) : '0;
         default: sc_result = '0;
      endcase
      sc_flags[3] = sc_result[WIDTH-1];
      sc_flags[2] = (sc_result == '0);
   end

   logic [WIDTH:0]     mul_add, div_shift;
   logic [WIDTH-1:0]   mul_hi, mul_lo, div_diff, div_rem, div_quo, a_mag, b_mag;
   logic [2*WIDTH-1:0] prod;
   logic               div_ge, is_smul;

   always_comb begin
      mul_add   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
      mul_hi    = mul_add[WIDTH:1];
      mul_lo    = {mul_add[0], lo_q[WIDTH-1:1]};
      prod      = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, md_q};
      div_diff  = div_shift[WIDTH-1:0] - md_q;
      div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
      div_quo   = {lo_q[WIDTH-2:0], div_ge};
      // magnitudes are unsigned, so the most-negative operand is exact
      is_smul   = (ALUControl == OP_SMUL);
      a_mag     = (is_smul && a[WIDTH-1]) ? -a : a;
      b_mag     = (is_smul && b[WIDTH-1]) ? -b : b;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      md_d     = md_q;
      neg_d    = neg_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      long_d   = long_q;
      flags_d  = flags_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d   = ALUControl;
               cnt_d  = '0;
               hi_d   = '0;
               busy_d = 1'b1;
               case (ALUControl)
                  OP_MUL, OP_SMUL, OP_UMUL: begin
                     state_d = S_MUL;
                     md_d    = a_mag;
                     lo_d    = b_mag;
                     neg_d   = is_smul && (a[WIDTH-1] ^ b[WIDTH-1]);
                  end
                  OP_DIV: begin
                     state_d = S_DIV;
                     md_d    = b;
                     lo_d    = a;
                     neg_d   = 1'b0;
                  end
                  default: begin
                     state_d  = S_DONE;
                     done_d   = 1'b1;
                     result_d = sc_result;
                     long_d   = '0;
                     flags_d  = sc_flags;
                  end
               endcase
            end
         end
         S_MUL: begin
            hi_d  = mul_hi;
            lo_d  = mul_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               result_d = prod[WIDTH-1:0];
               if (op_q == OP_MUL) begin
                  long_d  = '0;
                  flags_d = {prod[WIDTH-1], prod[WIDTH-1:0] == '0, 2'b00};
               end else begin
                  long_d  = prod[2*WIDTH-1:WIDTH];
                  flags_d = {prod[2*WIDTH-1], prod == '0, 2'b00};
               end
            end
         end
         S_DIV: begin
            hi_d  = div_rem;
            lo_d  = div_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               result_d = div_quo;
`ifdef ALU_MC_REM_EN
               long_d   = div_rem;
`else
               long_d   = '0;
`endif
               flags_d  = {div_quo[WIDTH-1], div_quo == '0, 2'b00};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         md_q     <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         long_q   <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         md_q     <= md_d;
         neg_q    <= neg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         long_q   <= long_d;
         flags_q  <= flags_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign Result   = result_q;
   assign Long     = long_q;
   assign ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc: a 32-bit instance for the op table and a 16-bit
// instance for the multiply abort/restart sequence. Honors ALU_MC_REM_EN for DIV Long.
module tb_alu_mc;
   logic        clk = 1'b0;
   logic        reset;
   logic        s32, busy32, done32;
   logic [3:0]  c32, f32;
   logic [31:0] a32, b32, r32, l32;
   logic        s16, busy16, done16;
   logic [3:0]  c16, f16;
   logic [15:0] a16, b16, r16, l16;

   alu_mc #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start(s32), .ALUControl(c32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .Result(r32), .Long(l32), .ALUFlags(f32)
   );
   alu_mc #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .start(s16), .ALUControl(c16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .Result(r16), .Long(l16), .ALUFlags(f16)
   );

   always #5 clk = ~clk;

`ifdef ALU_MC_REM_EN
   localparam logic [31:0] REM_MASK = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] REM_MASK = 32'h0;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] res;
      logic [31:0] lng;
      logic [3:0]  fl;
   } vec_t;

   localparam int NV = 28;
   vec_t v[NV];

   task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      s32 = 1'b1; c32 = op; a32 = a; b32 = b;
      @(posedge clk); #1;
      // scramble inputs after acceptance; the result must not follow them
      s32 = 1'b0; c32 = ~op; a32 = ~a; b32 = b + 32'd7;
      lat = 1;
      while (!done32 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run16(input int rst_at, output int lat);
      s16 = 1'b1; c16 = 4'b0110; a16 = 16'hFFFF; b16 = 16'hFFFF;
      @(posedge clk); #1;
      s16 = 1'b0; a16 = '0; b16 = '0;
      lat = 1;
      while (!done16 && lat < 40) begin
         reset = (lat == rst_at);
         @(posedge clk); #1;
         lat++;
      end
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      v[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h1,        1,  32'h80000000, 32'h0, 4'b1001};
      v[1]  = '{4'b0001, 32'h5,        32'h5,        1,  32'h0,        32'h0, 4'b0110};
      v[2]  = '{4'b0001, 32'h3,        32'h5,        1,  32'hFFFFFFFE, 32'h0, 4'b1000};
      v[3]  = '{4'b0000, 32'hFFFFFFFF, 32'h1,        1,  32'h0,        32'h0, 4'b0110};
      v[4]  = '{4'b0001, 32'h80000000, 32'h1,        1,  32'h7FFFFFFF, 32'h0, 4'b0011};
      v[5]  = '{4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 1,  32'h00F000F0, 32'h0, 4'b0000};
      v[6]  = '{4'b0011, 32'h80000000, 32'h1,        1,  32'h80000001, 32'h0, 4'b1000};
      v[7]  = '{4'b1000, 32'hAAAAAAAA, 32'h55555555, 1,  32'hFFFFFFFF, 32'h0, 4'b1000};
      v[8]  = '{4'b1001, 32'h123,      32'h80000000, 1,  32'h80000000, 32'h0, 4'b1000};
      v[9]  = '{4'b1010, 32'h1,        32'd31,       1,  32'h80000000, 32'h0, 4'b1000};
      v[10] = '{4'b1010, 32'h1,        32'd32,       1,  32'h0,        32'h0, 4'b0100};
      v[11] = '{4'b1010, 32'h3,        32'h101,      1,  32'h0,        32'h0, 4'b0100};
      v[12] = '{4'b1010, 32'h0000F00F, 32'd4,        1,  32'h000F00F0, 32'h0, 4'b0000};
      v[13] = '{4'b1011, 32'h5,        32'h6,        1,  32'h0,        32'h0, 4'b0100};
      v[14] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,  32'h0,        32'h0, 4'b0100};
      v[15] = '{4'b0100, 32'h12345,    32'h1000,     33, 32'h12345000, 32'h0, 4'b0000};
      v[16] = '{4'b0100, 32'hFFFFFFFF, 32'h2,        33, 32'hFFFFFFFE, 32'h0, 4'b1000};
      v[17] = '{4'b0101, 32'hFFFFFFFE, 32'h3,        33, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1000};
      v[18] = '{4'b0101, 32'h80000000, 32'h80000000, 33, 32'h0,        32'h40000000, 4'b0000};
      v[19] = '{4'b0101, 32'h80000000, 32'h1,        33, 32'h80000000, 32'hFFFFFFFF, 4'b1000};
      v[20] = '{4'b0101, 32'h0,        32'hFFFFFFFB, 33, 32'h0,        32'h0, 4'b0100};
      v[21] = '{4'b0101, 32'hFFFFFFF9, 32'hFFFFFFFD, 33, 32'h15,       32'h0, 4'b0000};
      v[22] = '{4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h1,        32'hFFFFFFFE, 4'b1000};
      v[23] = '{4'b0111, 32'd100,      32'd7,        33, 32'd14,       32'd2 & REM_MASK, 4'b0000};
      v[24] = '{4'b0111, 32'hFFFFFFFF, 32'd10,       33, 32'h19999999, 32'd5 & REM_MASK, 4'b0000};
      v[25] = '{4'b0111, 32'd3,        32'h80000000, 33, 32'h0,        32'd3 & REM_MASK, 4'b0100};
      v[26] = '{4'b0111, 32'd5,        32'd0,        33, 32'hFFFFFFFF, 32'd5 & REM_MASK, 4'b1000};
      v[27] = '{4'b0011, 32'h0,        32'h2,        1,  32'h2,        32'h0, 4'b0000};

      reset = 1'b1;
      s32 = 1'b0; c32 = '0; a32 = '0; b32 = '0;
      s16 = 1'b0; c16 = '0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst32 busy/done", 64'({busy32, done32}), 64'd0);
      chk("rst32 outputs", {r32, l32}, 64'd0);
      chk("rst32 flags", 64'(f32), 64'd0);
      chk("rst16 outputs", 64'({busy16, done16, r16, l16, f16}), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         run32(v[i].op, v[i].a, v[i].b, lat);
         chk($sformatf("v%0d latency", i), 64'(lat), 64'(v[i].lat));
         chk($sformatf("v%0d Result", i), 64'(r32), 64'(v[i].res));
         chk($sformatf("v%0d Long", i), 64'(l32), 64'(v[i].lng));
         chk($sformatf("v%0d ALUFlags", i), 64'(f32), 64'(v[i].fl));
         @(posedge clk); #1;
         chk($sformatf("v%0d hold/done", i), 64'({done32, r32}), 64'({1'b0, v[i].res}));
         $display("vec %0d op=%b a=%h b=%h lat=%0d Result=%h Long=%h flags=%b",
                  i, v[i].op, v[i].a, v[i].b, lat, r32, l32, f32);
      end

      // DIV by zero with start pulses while busy, then start during done
      s32 = 1'b1; c32 = 4'b0111; a32 = 32'd5; b32 = 32'd0;
      @(posedge clk); #1;
      s32 = 1'b0;
      lat = 1;
      while (!done32 && lat < 100) begin
         s32 = (lat == 3 || lat == 10);
         c32 = 4'b0000; a32 = 32'd1; b32 = 32'd1;
         if (lat == 5) chk("div0 busy mid-op", 64'(busy32), 64'd1);
         @(posedge clk); #1;
         lat++;
      end
      chk("div0 latency", 64'(lat), 64'd33);
      chk("div0 Result/Long", {r32, l32}, {32'hFFFFFFFF, 32'd5 & REM_MASK});
      $display("div0 seq lat=%0d Result=%h Long=%h", lat, r32, l32);
      s32 = 1'b1;
      @(posedge clk); #1;
      s32 = 1'b0;
      chk("start-in-done ignored", 64'({busy32, done32}), 64'd0);
      @(posedge clk); #1;
      chk("start-in-done no late done", 64'({done32, r32}), 64'({1'b0, 32'hFFFFFFFF}));
      $display("start during done seq busy=%b done=%b", busy32, done32);

      // reset together with start wins
      s32 = 1'b1; c32 = 4'b0000; a32 = 32'd1; b32 = 32'd1; reset = 1'b1;
      @(posedge clk); #1;
      s32 = 1'b0; reset = 1'b0;
      chk("reset+start busy", 64'(busy32), 64'd0);
      @(posedge clk); #1;
      chk("reset+start no done", 64'({done32, r32}), 64'd0);
      $display("reset+start seq busy=%b done=%b Result=%h", busy32, done32, r32);

      // 16-bit UMUL: complete, abort by reset at cycle 8, then complete again
      run16(0, lat);
      chk("umul16 latency", 64'(lat), 64'd17);
      chk("umul16 Long/Result", 64'({l16, r16}), 64'({16'hFFFE, 16'h0001}));
      chk("umul16 flags", 64'(f16), 64'(4'b1000));
      $display("umul16 lat=%0d Long=%h Result=%h", lat, l16, r16);
      @(posedge clk); #1;
      run16(8, lat);
      chk("umul16 abort no done", 64'(lat), 64'd40);
      chk("umul16 abort outputs", 64'({busy16, done16, r16, l16, f16}), 64'd0);
      $display("umul16 abort lat=%0d busy=%b Result=%h Long=%h", lat, busy16, r16, l16);
      run16(0, lat);
      chk("umul16 rerun latency", 64'(lat), 64'd17);
      chk("umul16 rerun Long/Result", 64'({l16, r16}), 64'({16'hFFFE, 16'h0001}));
      $display("umul16 rerun lat=%0d Long=%h Result=%h", lat, l16, r16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, even).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port ALUControl  input  4  operation code, sampled at acceptance.
REQ-006 SHALL have ports a, b  input  WIDTH  operands, sampled at acceptance.
REQ-007 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse; Result/Long/ALUFlags valid.
REQ-009 SHALL have port Result  output  WIDTH  low result word.
REQ-010 SHALL have port Long  output  WIDTH  high product word or remainder; else 0.
REQ-011 SHALL have port ALUFlags  output  4  {N,Z,C,V}.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE; IDLE->DONE for single-cycle ops, IDLE->MUL for 0100/0101/0110, IDLE->DIV for 0111, MUL/DIV->DONE after WIDTH iterations, DONE->IDLE always.
REQ-013 Codes: 000x ADD/SUB (a+~b+1 for SUB); 0010 AND; 0011 ORR; 1000 EOR; 1001 MOV (b); 1010 LSL (a<<b[log2(WIDTH)-1:0], b>=WIDTH gives 0); 0100 MUL low word; 0101 SMUL signed 2*WIDTH; 0110 UMUL unsigned 2*WIDTH; 0111 DIV unsigned quotient; 1011..1111 Result=0.
REQ-014 Single-cycle ops SHALL assert done exactly 1 cycle after acceptance.
REQ-015 MUL/SMUL/UMUL SHALL use iterative shift-add, one partial product per cycle; done exactly WIDTH+1 cycles after acceptance.
REQ-016 SMUL SHALL multiply operand magnitudes and negate the 2*WIDTH product when a and b signs differ; most-negative operands SHALL be handled exactly.
REQ-017 DIV SHALL use restoring division, one quotient bit per cycle; done exactly WIDTH+1 cycles after acceptance.
REQ-018 DIV with b==0 SHALL return Result all ones, Long=a (when remainder enabled), same latency.
REQ-019 start while busy or in DONE SHALL be ignored without affecting the operation in flight.
REQ-020 start in the cycle done is high SHALL be ignored; next acceptance earliest the following cycle.
REQ-021 Operand or ALUControl changes after acceptance SHALL NOT affect the result.
REQ-022 Result, Long, ALUFlags SHALL be registered, update only on the cycle done rises, and hold until the next done.
REQ-023 N SHALL be Long[WIDTH-1] for SMUL/UMUL, else Result[WIDTH-1].
REQ-024 Z SHALL be (Long==0 && Result==0) for SMUL/UMUL, else Result==0.
REQ-025 C SHALL be the carry out of the WIDTH+1-bit sum for ADD/SUB, else 0.
REQ-026 V SHALL be signed overflow of ADD/SUB, else 0.

Reset
REQ-027 reset SHALL force IDLE, busy=0, done=0, Result=0, Long=0, ALUFlags=0 on the next clk edge.
REQ-028 reset during MUL/DIV SHALL abort the operation with no done pulse.
REQ-029 reset asserted together with start SHALL win; start SHALL be dropped.

Configuration
REQ-030 Macro ALU_MC_REM_EN defined: DIV SHALL drive the remainder on Long.
REQ-031 ALU_MC_REM_EN undefined: DIV SHALL drive Long=0 and the remainder register SHALL be omitted; all else unchanged.

Verification
REQ-032 WIDTH=32, ADD a=0x7FFFFFFF b=1 -> done at cycle 1, Result=0x80000000, ALUFlags=1001.
REQ-033 WIDTH=32, SMUL a=0xFFFFFFFE b=3 -> done at cycle 33, Long=0xFFFFFFFF, Result=0xFFFFFFFA, N=1 Z=0.
REQ-034 WIDTH=32, DIV a=100 b=7 -> done at cycle 33, Result=14; Long=2 with ALU_MC_REM_EN, Long=0 without.
REQ-035 WIDTH=32, DIV a=5 b=0 -> Result=0xFFFFFFFF, Long=5 with ALU_MC_REM_EN; start pulses during busy ignored.
REQ-036 WIDTH=16, UMUL a=0xFFFF b=0xFFFF, reset at cycle 8 -> no done, all outputs 0; repeat without reset -> Long=0xFFFE, Result=0x0001 at cycle 17.
